seven_seg_capture: RTL and testbench

//  Reverse path of the hex-to-7-segment decoder: watches a multiplexed,

---
 rtl/seven_seg_capture.sv | 242 ++++++++++++++++++++++++
 tb/tb_seven_seg_capture.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_capture
// Purpose  : Watches a multiplexed, active-low 7-segment bus (segments plus
//            digit selects) and rebuilds the displayed hex nibble, decimal
//            point and glyph legality for every digit. The bus is
//            asynchronous to clk_i. A value is captured once it has been
//            stable for STABLE_CYCLES synchronized cycles.
// Ports    : clk_i          - system clock
//            rst_ni         - asynchronous reset, active low
//            seg_i[7:0]     - segments, active low, [6:0]=g..a, [7]=dp
//            dig_i          - digit selects, active low, one-hot-low when valid
//            clear_i        - synchronous clear of the captured state
//            value_o        - captured nibbles, digit k at [4k+3:4k]
//            dp_o           - captured decimal points, 1 = lit
//            digit_ok_o     - 1 = last capture of digit k was a legal glyph
//            frame_valid_o  - 1-cycle pulse, every digit captured since last frame
//            error_o        - 1-cycle pulse, illegal glyph or several selects low
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [7:0]            seg_i,
    input  logic [DIGITS-1:0]     dig_i,
    input  logic                  clear_i,
    output logic [4*DIGITS-1:0]   value_o,
    output logic [DIGITS-1:0]     dp_o,
    output logic [DIGITS-1:0]     digit_ok_o,
    output logic                  frame_valid_o,
    output logic                  error_o
);

    localparam int               BUS_W    = DIGITS + 8;
    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizer plus one delay stage for change detection.
    // Reset value is all ones, i.e. an idle (dark, deselected) bus.
    // ------------------------------------------------------------------
    logic [BUS_W-1:0] r_sync1;
    logic [BUS_W-1:0] r_sync2;
    logic [BUS_W-1:0] r_prev;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_prev  <= '1;
        end else begin
            r_sync1 <= {dig_i, seg_i};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    logic [DIGITS-1:0] w_dig_s;
    logic [7:0]        w_seg_s;
    logic              w_same;

    assign w_dig_s = r_sync2[BUS_W-1:8];
    assign w_seg_s = r_sync2[7:0];
    assign w_same  = (r_sync2 == r_prev);

    // ------------------------------------------------------------------
    // Stability FSM: one capture per stable episode, then park in HELD
    // until the bus moves again.
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_capture;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            ST_WAIT: begin
                w_cnt_next = '0;
                if (w_same) begin
                    w_state_next = ST_SETTLE;
                    w_cnt_next   = CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (!w_same) begin
                    w_state_next = ST_WAIT;
                    w_cnt_next   = '0;
                end else begin
                    if (r_cnt != CNT_SAT) begin
                        w_cnt_next = r_cnt + CNT_ONE;
                    end
                    if (r_cnt == CNT_LAST) begin
                        w_capture    = 1'b1;
                        w_state_next = ST_HELD;
                    end
                end
            end
            ST_HELD: begin
                // Counter is frozen here so it can never wrap on a long hold.
                if (!w_same) begin
                    w_state_next = ST_WAIT;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_WAIT;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Glyph decoder: returns {hit, nibble} for an active-low g..a pattern.
    // ------------------------------------------------------------------
    function automatic logic [4:0] f_decode(input logic [6:0] glyph);
        logic [4:0] res;
        res = 5'h00;
        case (glyph)
            7'h40:   res = {1'b1, 4'h0};
            7'h79:   res = {1'b1, 4'h1};
            7'h24:   res = {1'b1, 4'h2};
            7'h30:   res = {1'b1, 4'h3};
            7'h19:   res = {1'b1, 4'h4};
            7'h12:   res = {1'b1, 4'h5};
            7'h02:   res = {1'b1, 4'h6};
            7'h78:   res = {1'b1, 4'h7};
            7'h00:   res = {1'b1, 4'h8};
            7'h10:   res = {1'b1, 4'h9};
            7'h08:   res = {1'b1, 4'hA};
            7'h03:   res = {1'b1, 4'hB};
            7'h46:   res = {1'b1, 4'hC};
            7'h21:   res = {1'b1, 4'hD};
            7'h06:   res = {1'b1, 4'hE};
            7'h0E:   res = {1'b1, 4'hF};
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    logic [DIGITS-1:0] w_sel;
    logic              w_sel_one;
    logic              w_sel_multi;
    logic [4:0]        w_dec;
    logic              w_hit;
    logic              w_blank;
    logic              w_bad;
    logic [DIGITS-1:0] w_mask_set;

    assign w_sel       = ~w_dig_s;
    assign w_sel_one   = ($countones(w_sel) == 1);
    assign w_sel_multi = ($countones(w_sel) > 1);
    assign w_dec       = f_decode(w_seg_s[6:0]);
    assign w_hit       = w_dec[4];
    assign w_blank     = (w_seg_s[6:0] == 7'h7F);
    assign w_bad       = !w_hit && !w_blank;

    // ------------------------------------------------------------------
    // Captured state and pulses
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_dp;
    logic [DIGITS-1:0]   r_ok;
    logic [DIGITS-1:0]   r_mask;
    logic                r_frame;
    logic                r_error;

    assign w_mask_set = r_mask | w_sel;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_value <= '0;
            r_dp    <= '0;
            r_ok    <= '0;
            r_mask  <= '0;
            r_frame <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            r_error <= 1'b0;
            if (clear_i) begin
                // Clear wins over a coincident capture; that capture is lost.
                r_value <= '0;
                r_dp    <= '0;
                r_ok    <= '0;
                r_mask  <= '0;
            end else if (w_capture) begin
                if (w_sel_multi) begin
                    r_error <= 1'b1;
                end else if (w_sel_one) begin
                    for (int k = 0; k < DIGITS; k++) begin
                        if (w_sel[k]) begin
                            r_value[4*k +: 4] <= w_hit ? w_dec[3:0] : 4'h0;
                            r_ok[k]           <= w_hit;
                            r_dp[k]           <= ~w_seg_s[7];
                        end
                    end
                    r_error <= w_bad;
                    // Completing the set restarts the mask in the same edge.
                    if (&w_mask_set) begin
                        r_mask  <= '0;
                        r_frame <= 1'b1;
                    end else begin
                        r_mask  <= w_mask_set;
                    end
                end
            end
        end
    end

    assign value_o       = r_value;
    assign dp_o          = r_dp;
    assign digit_ok_o    = r_ok;
    assign frame_valid_o = r_frame;
    assign error_o       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_capture
// Purpose  : Self-checking bench for seven_seg_capture (DIGITS=4,
//            STABLE_CYCLES=16). Directed vector table, hand-written corner
//            sequences, then randomized episodes checked every cycle
//            against a run-length based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_capture;

    localparam int DIGITS = 4;
    localparam int S      = 16;

    logic        clk_i   = 1'b0;
    logic        rst_ni  = 1'b0;
    logic [7:0]  seg_i   = 8'hFF;
    logic [3:0]  dig_i   = 4'hF;
    logic        clear_i = 1'b0;
    logic [15:0] value_o;
    logic [3:0]  dp_o;
    logic [3:0]  digit_ok_o;
    logic        frame_valid_o;
    logic        error_o;

    int n_checks = 0;
    int n_errors = 0;
    int errs_seen = 0;
    int frames_seen = 0;

    seven_seg_capture #(
        .DIGITS        (DIGITS),
        .STABLE_CYCLES (S)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .seg_i         (seg_i),
        .dig_i         (dig_i),
        .clear_i       (clear_i),
        .value_o       (value_o),
        .dp_o          (dp_o),
        .digit_ok_o    (digit_ok_o),
        .frame_valid_o (frame_valid_o),
        .error_o       (error_o)
    );

    always #5 clk_i = ~clk_i;

    // ------------------------------------------------------------------
    // Reference model. A value sampled on the bus is captured exactly
    // S+2 edges after the first edge that saw it, provided it was seen on
    // S+1 consecutive edges. The history queue holds the sampled value and
    // its run length for the last edges.
    // ------------------------------------------------------------------
    logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [11:0] smp;
        int          rl;
    } hist_t;

    hist_t       hq[$];
    logic [11:0] m_last;
    int          m_rl;
    logic [15:0] m_value;
    logic [3:0]  m_dp;
    logic [3:0]  m_ok;
    logic [3:0]  m_mask;
    logic        m_err;
    logic        m_frame;

    task automatic model_reset();
        hist_t h;
        hq.delete();
        m_last  = 12'hFFF;
        m_rl    = 1000;
        h.smp   = 12'hFFF;
        h.rl    = 1000;
        hq.push_back(h);
        hq.push_back(h);
        m_value = '0;
        m_dp    = '0;
        m_ok    = '0;
        m_mask  = '0;
        m_err   = 1'b0;
        m_frame = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] d, input logic [7:0] s, input logic c);
        hist_t      h;
        logic [3:0] sel;
        int         k;
        int         g;
        if ({d, s} == m_last) begin
            if (m_rl < 100000) m_rl++;
        end else begin
            m_rl = 1;
        end
        m_last = {d, s};
        h.smp  = m_last;
        h.rl   = m_rl;
        hq.push_back(h);
        h = hq.pop_front();
        m_err   = 1'b0;
        m_frame = 1'b0;
        if (c) begin
            m_value = '0;
            m_dp    = '0;
            m_ok    = '0;
            m_mask  = '0;
        end else if (h.rl == S + 1) begin
            sel = ~h.smp[11:8];
            if ($countones(sel) > 1) begin
                m_err = 1'b1;
            end else if ($countones(sel) == 1) begin
                k = 0;
                for (int i = 0; i < DIGITS; i++) if (sel[i]) k = i;
                g = -1;
                for (int i = 0; i < 16; i++) if (GLYPH[i] == h.smp[6:0]) g = i;
                if (g >= 0) begin
                    m_value[4*k +: 4] = g[3:0];
                    m_ok[k] = 1'b1;
                end else begin
                    m_value[4*k +: 4] = 4'h0;
                    m_ok[k] = 1'b0;
                    if (h.smp[6:0] != 7'h7F) m_err = 1'b1;
                end
                m_dp[k]   = ~h.smp[7];
                m_mask[k] = 1'b1;
                if (m_mask == 4'hF) begin
                    m_frame = 1'b1;
                    m_mask  = '0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, let the edge sample them, compare with model.
    task automatic tick(input logic [3:0] d, input logic [7:0] s, input logic c);
        dig_i   = d;
        seg_i   = s;
        clear_i = c;
        @(posedge clk_i);
        #1;
        model_step(d, s, c);
        n_checks++;
        if ({value_o, dp_o, digit_ok_o, frame_valid_o, error_o} !==
            {m_value, m_dp, m_ok, m_frame, m_err}) begin
            n_errors++;
            $display("FAIL model t=%0t got v=%h dp=%b ok=%b fr=%b er=%b exp v=%h dp=%b ok=%b fr=%b er=%b",
                     $time, value_o, dp_o, digit_ok_o, frame_valid_o, error_o,
                     m_value, m_dp, m_ok, m_frame, m_err);
        end
        errs_seen   += int'(error_o);
        frames_seen += int'(frame_valid_o);
    endtask

    typedef struct {
        logic [3:0]  dig;
        logic [7:0]  seg;
        int          hold;
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  ok;
        int          errs;
        int          frames;
    } vec_t;

    vec_t vt[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        logic [3:0] d;
        logic [7:0] s;
        int kind;
        int hold;

        vt[0]  = '{4'b1110, 8'hA4,  20, 16'h0002, 4'b0000, 4'b0001, 0, 0};
        vt[1]  = '{4'b1110, 8'h99,  20, 16'h0004, 4'b0000, 4'b0001, 0, 0};
        vt[2]  = '{4'b1101, 8'hB0,  20, 16'h0034, 4'b0000, 4'b0011, 0, 0};
        vt[3]  = '{4'b1011, 8'hA4,  20, 16'h0234, 4'b0000, 4'b0111, 0, 0};
        vt[4]  = '{4'b0111, 8'hF9,  20, 16'h1234, 4'b0000, 4'b1111, 0, 1};
        vt[5]  = '{4'b1110, 8'hC0,  10, 16'h1234, 4'b0000, 4'b1111, 0, 0};
        vt[6]  = '{4'b1110, 8'h92,  10, 16'h1234, 4'b0000, 4'b1111, 0, 0};
        vt[7]  = '{4'b1110, 8'h80,  10, 16'h1234, 4'b0000, 4'b1111, 0, 0};
        vt[8]  = '{4'b1100, 8'hA4,  20, 16'h1234, 4'b0000, 4'b1111, 1, 0};
        vt[9]  = '{4'b1110, 8'hFF,  20, 16'h1230, 4'b0000, 4'b1110, 0, 0};
        vt[10] = '{4'b1110, 8'hD5,  20, 16'h1230, 4'b0000, 4'b1110, 1, 0};
        vt[11] = '{4'b1011, 8'h40, 100, 16'h1030, 4'b0100, 4'b1110, 0, 0};
        vt[12] = '{4'b1101, 8'hD5, 100, 16'h1000, 4'b0100, 4'b1100, 1, 0};

        model_reset();
        #23;
        chk("reset_outputs", {11'd0, value_o, dp_o, digit_ok_o, frame_valid_o, error_o}, 32'd0);
        rst_ni = 1'b1;

        // Capture latency from the first sampling edge.
        first = -1;
        for (int j = 0; j < 30; j++) begin
            tick(4'b1110, 8'hA4, 1'b0);
            if (first < 0 && value_o[3:0] == 4'h2) first = j;
        end
        chk("latency_first", first, 18);
        chk("latency_ok0", {31'd0, digit_ok_o[0]}, 1);
        repeat (5) tick(4'hF, 8'hFF, 1'b0);

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            errs_seen   = 0;
            frames_seen = 0;
            for (int t = 0; t < vt[i].hold; t++) tick(vt[i].dig, vt[i].seg, 1'b0);
            chk($sformatf("vec%0d_value", i), {16'd0, value_o}, {16'd0, vt[i].value});
            chk($sformatf("vec%0d_dp", i), {28'd0, dp_o}, {28'd0, vt[i].dp});
            chk($sformatf("vec%0d_ok", i), {28'd0, digit_ok_o}, {28'd0, vt[i].ok});
            chk($sformatf("vec%0d_errs", i), errs_seen, vt[i].errs);
            chk($sformatf("vec%0d_frames", i), frames_seen, vt[i].frames);
        end

        // Clear on the capture edge of a frame-completing digit.
        errs_seen   = 0;
        frames_seen = 0;
        for (int j = 0; j < 30; j++) tick(4'b0111, 8'hF9, (j == 18));
        chk("clear_value", {16'd0, value_o}, 32'd0);
        chk("clear_ok", {28'd0, digit_ok_o}, 32'd0);
        chk("clear_dp", {28'd0, dp_o}, 32'd0);
        chk("clear_frames", frames_seen, 0);
        chk("clear_errs", errs_seen, 0);

        // Reset in the middle of a settling episode.
        repeat (20) tick(4'b1101, 8'h24, 1'b0);
        chk("pre_reset_value", {16'd0, value_o}, 32'h0020);
        repeat (10) tick(4'b1110, 8'h19, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_reset", {11'd0, value_o, dp_o, digit_ok_o, frame_valid_o, error_o}, 32'd0);
        model_reset();
        #1;
        rst_ni = 1'b1;
        first = -1;
        for (int j = 0; j < 30; j++) begin
            tick(4'b1110, 8'h19, 1'b0);
            if (first < 0 && value_o[3:0] == 4'h4) first = j;
        end
        chk("post_reset_latency", first, 18);

        // Randomized episodes.
        for (int e = 0; e < 80; e++) begin
            kind = $urandom_range(0, 9);
            d = 4'b1111;
            d[$urandom_range(0, 3)] = 1'b0;
            s[7]   = 1'($urandom_range(0, 1));
            s[6:0] = GLYPH[$urandom_range(0, 15)];
            case (kind)
                0: d = 4'b1111;
                1: d = d & ~(4'b0001 << $urandom_range(0, 3));
                2: s[6:0] = 7'($urandom);
                3: s[6:0] = 7'h7F;
                default: ;
            endcase
            hold = $urandom_range(1, 40);
            for (int t = 0; t < hold; t++) tick(d, s, ($urandom_range(0, 59) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
